// File: rtl/arb_requester_if.sv
// Command/arbiter bundle for arb_requester.
// master: requester side (takes commands and grants, drives req/beat/status).
// slave : environment side (transfer engines plus the arbiter).
// Signals:
//   cmd_valid/cmd_len/cmd_ready  per-channel burst command handshake
//   req, gnt_0, gnt_1            two-line arbiter protocol
//   beat, done, timeout          per-channel transfer strobes
//   spurious, gnt_conflict       sticky protocol-error flags
interface arb_requester_if #(
    parameter int unsigned LEN_W = 4
);
    logic [1:0]         cmd_valid;
    logic [2*LEN_W-1:0] cmd_len;
    logic [1:0]         cmd_ready;
    logic [1:0]         req;
    logic               gnt_0;
    logic               gnt_1;
    logic [1:0]         beat;
    logic [1:0]         done;
    logic [1:0]         timeout;
    logic [1:0]         spurious;
    logic               gnt_conflict;

    modport master (
        input  cmd_valid, cmd_len, gnt_0, gnt_1,
        output cmd_ready, req, beat, done, timeout, spurious, gnt_conflict
    );

    modport slave (
        output cmd_valid, cmd_len, gnt_0, gnt_1,
        input  cmd_ready, req, beat, done, timeout, spurious, gnt_conflict
    );
endinterface

// File: rtl/arb_requester.sv
// Two-channel client for the two-line grant arbiter. Each channel takes a
// burst command, requests the arbiter, waits for its grant (with timeout),
// strobes one beat per granted cycle and then releases for one cycle.
// Ports:
//   clock  system clock, posedge
//   reset  synchronous, active-high
//   bus    arb_requester_if.master: command handshake, req/gnt, beat/done/
//          timeout strobes, sticky spurious/gnt_conflict flags
module arb_requester #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clock,
    input  logic           reset,
    arb_requester_if.master bus
);
    localparam int unsigned CNT_W  = LEN_W + 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, OWN, REL} state_t;

    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] remaining [2];
    logic [WAIT_W-1:0] wait_cnt [2];

    logic [1:0] gnt;
    logic [1:0] req_c;
    logic [1:0] ready_c;
    logic [1:0] beat_c;
    logic [1:0] accept_c;
    logic [1:0] last_beat_c;
    logic [1:0] give_up_c;

    logic [1:0] done_q;
    logic [1:0] timeout_q;
    logic [1:0] spurious_q;
    logic       conflict_q;

    assign gnt = {bus.gnt_1, bus.gnt_0};

    // State register
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                state_q[i] <= IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Next-state logic; a grant in the last WAIT cycle beats the timeout
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: if (accept_c[i]) state_d[i] = WAIT;
                WAIT: begin
                    if (gnt[i]) begin
                        state_d[i] = OWN;
                    end else if (give_up_c[i]) begin
                        state_d[i] = REL;
                    end
                end
                OWN:  if (last_beat_c[i]) state_d[i] = REL;
                REL:  state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Output decode from registered state; beat follows the live grant
    always_comb begin
        req_c       = '0;
        ready_c     = '0;
        beat_c      = '0;
        accept_c    = '0;
        last_beat_c = '0;
        give_up_c   = '0;
        for (int i = 0; i < 2; i++) begin
            req_c[i]       = (state_q[i] == WAIT) || (state_q[i] == OWN);
            ready_c[i]     = (state_q[i] == IDLE);
            beat_c[i]      = (state_q[i] == OWN) && gnt[i];
            accept_c[i]    = ready_c[i] && bus.cmd_valid[i];
            last_beat_c[i] = beat_c[i] && (remaining[i] == CNT_W'(1));
            give_up_c[i]   = (state_q[i] == WAIT) && !gnt[i] &&
                             (wait_cnt[i] == WAIT_W'(TIMEOUT - 1));
        end
    end

    // Burst/wait counters, completion strobes and sticky protocol flags
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                remaining[i] <= '0;
                wait_cnt[i]  <= '0;
            end
            done_q     <= '0;
            timeout_q  <= '0;
            spurious_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept_c[i]) begin
                    remaining[i] <= CNT_W'(bus.cmd_len[i*LEN_W +: LEN_W]) + CNT_W'(1);
                    wait_cnt[i]  <= '0;
                end else begin
                    if ((state_q[i] == WAIT) && !gnt[i] && !give_up_c[i]) begin
                        wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                    end
                    if (beat_c[i]) begin
                        remaining[i] <= remaining[i] - CNT_W'(1);
                    end
                end
                spurious_q[i] <= spurious_q[i] |
                                 (gnt[i] && ((state_q[i] == IDLE) || (state_q[i] == REL)));
            end
            done_q     <= last_beat_c;
            timeout_q  <= give_up_c;
            conflict_q <= conflict_q | (bus.gnt_0 & bus.gnt_1);
        end
    end

    assign bus.req          = req_c;
    assign bus.cmd_ready    = ready_c;
    assign bus.beat         = beat_c;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.spurious     = spurious_q;
    assign bus.gnt_conflict = conflict_q;
endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester (LEN_W=4, TIMEOUT=16). Inputs are driven
// 1 time unit after each rising edge and outputs checked 1 unit later.
module tb_arb_requester;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    arb_requester_if #(.LEN_W(4)) bus ();

    arb_requester #(
        .LEN_W   (4),
        .TIMEOUT (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [6:0] gap_gnt;
        logic [6:0] gap_beat;
        int b0, b1, d0, d1, to_cnt, beats;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.cmd_valid = 2'b00;
        bus.cmd_len   = 8'h00;
        bus.gnt_0     = 1'b0;
        bus.gnt_1     = 1'b0;

        // Reset held two cycles
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_req", 32'(bus.req), 32'h0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h3);
        chk("rst_beat", 32'(bus.beat), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_timeout", 32'(bus.timeout), 32'h0);
        chk("rst_spurious", 32'(bus.spurious), 32'h0);
        chk("rst_conflict", 32'(bus.gnt_conflict), 32'h0);

        // Basic 4-beat burst on channel 0, grant from t+3
        step();
        bus.cmd_len = 8'h03;
        bus.cmd_valid = 2'b01;
        #1 chk("b_ready_t", 32'(bus.cmd_ready), 32'h3);
        step(); bus.cmd_valid = 2'b00;
        #1 chk("b_req_t1", 32'(bus.req), 32'h1);
        step();
        #1 chk("b_req_t2", 32'(bus.req), 32'h1);
        chk("b_beat_t2", 32'(bus.beat), 32'h0);
        step(); bus.gnt_0 = 1'b1;
        #1 chk("b_beat_t3", 32'(bus.beat), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            #1 chk("b_beat_own", 32'(bus.beat), 32'h1);
        end
        step(); bus.gnt_0 = 1'b0;
        #1 chk("b_done_t8", 32'(bus.done), 32'h1);
        chk("b_req_t8", 32'(bus.req), 32'h0);
        chk("b_beat_t8", 32'(bus.beat), 32'h0);
        step();
        #1 chk("b_done_t9", 32'(bus.done), 32'h0);
        chk("b_ready_t9", 32'(bus.cmd_ready), 32'h3);

        // Grant gap of 2 cycles after the 2nd beat; pattern for t+3..t+9
        gap_gnt  = 7'b1100111;
        gap_beat = 7'b1100110;
        beats = 0;
        bus.cmd_len = 8'h03;
        bus.cmd_valid = 2'b01;
        step(); bus.cmd_valid = 2'b00;
        step();
        for (int k = 0; k < 7; k++) begin
            step(); bus.gnt_0 = gap_gnt[k];
            #1 chk("g_beat", 32'(bus.beat), 32'(gap_beat[k]));
            beats += int'(bus.beat[0]);
            chk("g_nodone", 32'(bus.done), 32'h0);
        end
        step(); bus.gnt_0 = 1'b0;
        #1 chk("g_done", 32'(bus.done), 32'h1);
        chk("g_beats", 32'(beats), 32'd4);
        step();
        #1 chk("g_ready", 32'(bus.cmd_ready), 32'h3);

        // Timeout on channel 1: 16 cycles of req, then one timeout pulse
        bus.cmd_len = 8'h20;
        bus.cmd_valid = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            step(); bus.cmd_valid = 2'b00;
            #1 chk("to_req", 32'(bus.req), 32'h2);
            chk("to_beat", 32'(bus.beat), 32'h0);
        end
        step();
        #1 chk("to_pulse", 32'(bus.timeout), 32'h2);
        chk("to_req_rel", 32'(bus.req), 32'h0);
        chk("to_nodone", 32'(bus.done), 32'h0);
        step();
        #1 chk("to_pulse_end", 32'(bus.timeout), 32'h0);
        chk("to_ready", 32'(bus.cmd_ready), 32'h3);

        // Grant in the 16th WAIT cycle wins over timeout; 3-beat burst
        bus.cmd_len = 8'h20;
        bus.cmd_valid = 2'b10;
        for (int k = 1; k <= 15; k++) begin
            step(); bus.cmd_valid = 2'b00;
            #1 chk("lg_req", 32'(bus.req), 32'h2);
        end
        step(); bus.gnt_1 = 1'b1;
        #1 chk("lg_req16", 32'(bus.req), 32'h2);
        chk("lg_beat16", 32'(bus.beat), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            #1 chk("lg_beat", 32'(bus.beat), 32'h2);
            chk("lg_notimeout", 32'(bus.timeout), 32'h0);
        end
        step(); bus.gnt_1 = 1'b0;
        #1 chk("lg_done", 32'(bus.done), 32'h2);
        chk("lg_timeout", 32'(bus.timeout), 32'h0);
        chk("lg_req_rel", 32'(bus.req), 32'h0);
        step();
        #1 chk("lg_ready", 32'(bus.cmd_ready), 32'h3);

        // Parallel: ch0 3 beats, ch1 5 beats, grants alternate
        b0 = 0; b1 = 0; d0 = 0; d1 = 0; to_cnt = 0;
        bus.cmd_len = 8'h42;
        bus.cmd_valid = 2'b11;
        #1 chk("p_ready", 32'(bus.cmd_ready), 32'h3);
        for (int c = 1; c <= 40; c++) begin
            step();
            bus.cmd_valid = 2'b00;
            bus.gnt_0 = (c % 2 == 0) && bus.req[0];
            bus.gnt_1 = (c % 2 == 1) && bus.req[1];
            #1;
            b0 += int'(bus.beat[0]);
            b1 += int'(bus.beat[1]);
            d0 += int'(bus.done[0]);
            d1 += int'(bus.done[1]);
            to_cnt += int'(bus.timeout[0]) + int'(bus.timeout[1]);
        end
        bus.gnt_0 = 1'b0;
        bus.gnt_1 = 1'b0;
        chk("p_beats0", 32'(b0), 32'd3);
        chk("p_beats1", 32'(b1), 32'd5);
        chk("p_done0", 32'(d0), 32'd1);
        chk("p_done1", 32'(d1), 32'd1);
        chk("p_timeouts", 32'(to_cnt), 32'd0);
        chk("p_ready_end", 32'(bus.cmd_ready), 32'h3);
        chk("p_spurious", 32'(bus.spurious), 32'h0);
        chk("p_conflict", 32'(bus.gnt_conflict), 32'h0);

        // Protocol errors: spurious grant, then both grants together
        step(); bus.gnt_1 = 1'b1;
        step(); bus.gnt_1 = 1'b0;
        #1 chk("e_spur1", 32'(bus.spurious), 32'h2);
        chk("e_noconf", 32'(bus.gnt_conflict), 32'h0);
        step();
        #1 chk("e_spur1_sticky", 32'(bus.spurious), 32'h2);
        bus.gnt_0 = 1'b1;
        bus.gnt_1 = 1'b1;
        step(); bus.gnt_0 = 1'b0; bus.gnt_1 = 1'b0;
        #1 chk("e_conf", 32'(bus.gnt_conflict), 32'h1);
        chk("e_spur_both", 32'(bus.spurious), 32'h3);
        step();
        #1 chk("e_conf_sticky", 32'(bus.gnt_conflict), 32'h1);
        reset = 1'b1;
        step(); reset = 1'b0;
        #1 chk("e_conf_clr", 32'(bus.gnt_conflict), 32'h0);
        chk("e_spur_clr", 32'(bus.spurious), 32'h0);

        // Reset after 2 of 4 beats
        bus.cmd_len = 8'h03;
        bus.cmd_valid = 2'b01;
        step(); bus.cmd_valid = 2'b00;
        step();
        step(); bus.gnt_0 = 1'b1;
        step();
        #1 chk("r_beat1", 32'(bus.beat), 32'h1);
        step();
        #1 chk("r_beat2", 32'(bus.beat), 32'h1);
        step(); reset = 1'b1; bus.gnt_0 = 1'b0;
        step(); reset = 1'b0;
        #1 chk("r_req", 32'(bus.req), 32'h0);
        chk("r_beat", 32'(bus.beat), 32'h0);
        chk("r_done", 32'(bus.done), 32'h0);
        chk("r_ready", 32'(bus.cmd_ready), 32'h3);
        step();
        #1 chk("r_done_after", 32'(bus.done), 32'h0);
        chk("r_timeout_after", 32'(bus.timeout), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side companion to the two-line grant arbiter. Converts per-channel transfer commands into the arbiter's req[1:0] / gnt_0 / gnt_1 protocol.
- Each channel does the following in order:
  - accepts a burst command;
  - raises its request line;
  - waits for its grant, with a timeout;
  - issues one beat strobe per granted cycle;
  - releases the request.
- Sits between the local transfer engines and the arbiter. The two channels are independent copies of the same FSM plus shared protocol checking.

Parameters:
- LEN_W, 4, width of the burst-length field per channel. A burst is cmd_len+1 beats, so 1..2^LEN_W.
- TIMEOUT, 16, maximum number of WAIT cycles with request high and no grant before the request is abandoned. Must be >= 2.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  2  per-channel command valid; bit i is channel i.
- cmd_len  input  2*LEN_W  per-channel burst length minus one; channel i occupies bits [i*LEN_W +: LEN_W].
- cmd_ready  output  2  per-channel command accept.
- req  output  2  request lines to the arbiter; bit 0 pairs with gnt_0, bit 1 with gnt_1.
- gnt_0  input  1  grant for channel 0, from the arbiter.
- gnt_1  input  1  grant for channel 1, from the arbiter.
- beat  output  2  per-channel data-beat strobe, one per transferred beat.
- done  output  2  one-cycle pulse when a burst completes.
- timeout  output  2  one-cycle pulse when a request is abandoned.
- spurious  output  2  sticky flag: grant seen while the channel was not requesting.
- gnt_conflict  output  1  sticky flag: gnt_0 and gnt_1 high in the same cycle.

Behaviour:
- Reset (synchronous, active-high; clock is clock):
  - state = IDLE on both channels; req = 0, beat = 0, done = 0, timeout = 0, spurious = 0, gnt_conflict = 0.
  - The latched command is discarded. cmd_ready = 2'b11 in the first cycle after reset.
- Per-channel FSM states: IDLE, WAIT, OWN, REL. State is registered.
- Decoded outputs, all from registered state:
  - req[i] = (state is WAIT or OWN).
  - cmd_ready[i] = (state is IDLE).
- IDLE:
  - On cmd_valid[i] & cmd_ready[i], latch remaining = cmd_len+1 (LEN_W+1 bits), clear wait_cnt, go to WAIT.
  - req rises in the cycle after the handshake.
- WAIT:
  - If the grant is high: go to OWN. No beat is issued in this cycle.
  - Else if wait_cnt == TIMEOUT-1: go to REL and set timeout[i] for the first REL cycle.
  - Else: wait_cnt increments.
  - A grant in the final WAIT cycle takes precedence over timeout.
  - Net effect: req is high for exactly TIMEOUT cycles when no grant arrives.
- OWN:
  - beat[i] = (state is OWN) & grant, combinational.
  - Each beat decrements remaining. If the grant drops mid-burst, beat pauses and the channel stays in OWN; there is no timeout in OWN.
  - On the beat where remaining == 1, go to REL and set done[i] for the first REL cycle.
- REL:
  - Lasts exactly one cycle, with req = 0 so the arbiter can return to idle. Then go to IDLE.
  - done and timeout are never high in the same cycle.
- Protocol checks:
  - spurious[i] sets on any cycle where the grant is high while state is IDLE or REL.
  - gnt_conflict sets when gnt_0 & gnt_1.
  - Both flags are cleared only by reset. The FSM ignores grants outside WAIT/OWN.
- Channel independence: the channels never interact, and simultaneous commands on both are accepted in the same cycle.
- Reset mid-operation: from any state, the next cycle is IDLE with req = 0. There is no done or timeout pulse, and the partially transferred burst is abandoned.
- Counter widths: wait_cnt is clog2(TIMEOUT) bits; remaining is LEN_W+1 bits. Neither counter may wrap.

Test Plan:
- Reset check: hold reset 2 cycles, then release. Expect all outputs 0, cmd_ready = 2'b11, req = 2'b00.
- Basic burst, channel 0:
  - Stimulus: cmd_len = 3 accepted at cycle t; bench raises gnt_0 at t+3 and holds it.
  - Expect: req[0] high from t+1; beat[0] high at t+4..t+7 (4 beats); done[0] at t+8 with req[0] = 0; cmd_ready[0] = 1 at t+9.
- Grant gap: same burst, but gnt_0 drops for 2 cycles after the 2nd beat. Expect beat[0] low for those 2 cycles, exactly 4 beats total, done delayed by 2 cycles.
- Timeout, channel 1 (TIMEOUT = 16):
  - Stimulus: cmd accepted, no gnt_1 ever.
  - Expect: req[1] high for exactly 16 cycles, then timeout[1] pulse with req[1] = 0, zero beats, no done, cmd_ready[1] back the following cycle.
  - Repeat with gnt_1 raised in the 16th WAIT cycle: expect no timeout and a normal burst.
- Protocol errors:
  - Pulse gnt_1 while channel 1 is IDLE: spurious = 2'b10 and stays set.
  - Drive gnt_0 and gnt_1 together: gnt_conflict = 1.
  - Both flags clear only on reset.
- Reset mid-burst: assert reset after 2 of 4 beats. Expect the next cycle to show req = 0, beat = 0, no done, cmd_ready = 2'b11.
- Parallel channels: both channels accept in the same cycle with different lengths; grants alternate. Verify per-channel beat counts are independent and correct.
